// File: rtl/kogge.sv
// Kogge-Stone parallel-prefix adder: combinational Sum = A + B + Cin (MSB is carry-out),
// plus a registered copy Sum_r that is cleared asynchronously by rst.
module kogge #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N:0]   Sum,
    output logic [N:0]   Sum_r
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

    logic [N-1:0] p;
    logic [N-1:0] g0;
    logic [N-1:0] g_final;
    logic [N-1:0] carry;
    logic [N:0]   sum_r_d;
    logic [N:0]   sum_r_q;

    genvar gi;

    // Bit 0 absorbs Cin into its generate term so the tree yields true carries.
    generate
        for (gi = 0; gi < N; gi++) begin : g_pre
            assign p[gi] = A[gi] ^ B[gi];
            if (gi == 0) begin : g_bit0
                assign g0[gi] = (A[gi] & B[gi]) | ((A[gi] ^ B[gi]) & Cin);
            end else begin : g_bitn
                assign g0[gi] = A[gi] & B[gi];
            end
        end
    endgenerate

    // Prefix tree: level k combines each bit with the one 2^k below it.
    always_comb begin
        logic [N-1:0] g_cur;
        logic [N-1:0] p_cur;
        logic [N-1:0] g_nxt;
        logic [N-1:0] p_nxt;
        g_cur = g0;
        p_cur = p;
        g_nxt = g0;
        p_nxt = p;
        for (int k = 0; k < LEVELS; k++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = (1 << k); i < N; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << k)]);
                p_nxt[i] = p_cur[i] & p_cur[i - (1 << k)];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        g_final = g_cur;
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_sum
            if (gi == 0) begin : g_c0
                assign carry[gi] = Cin;
            end else begin : g_cn
                assign carry[gi] = g_final[gi-1];
            end
            assign Sum[gi] = p[gi] ^ carry[gi];
        end
    endgenerate

    assign Sum[N] = g_final[N-1];

    always_comb begin
        sum_r_d = Sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r_q <= '0;
        end else begin
            sum_r_q <= sum_r_d;
        end
    end

    assign Sum_r = sum_r_q;

endmodule

// File: tb/tb_kogge.sv
// Directed and random checks of the kogge adder: combinational Sum and registered Sum_r.
module tb_kogge;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [32:0] sum;
    logic [32:0] sum_r;

    int checks_cnt;
    int errors_cnt;

    kogge #(.N(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Sum   (sum),
        .Sum_r (sum_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%09h expected 0x%09h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%09h", tag, got);
        end
    endtask

    task automatic apply_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic cv, input logic [32:0] exp);
        a   = av;
        b   = bv;
        cin = cv;
        #2;
        check_val(tag, sum, exp);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] rexp;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        #3;
        check_val("reset_sum_r", sum_r, 33'h0_0000_0000);

        apply_vec("zero",          32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
        apply_vec("ripple_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        apply_vec("max_all",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        apply_vec("prop_cin1",     32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
        apply_vec("prop_cin0",     32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
        apply_vec("msb_carry",     32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
        apply_vec("mixed",         32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
        apply_vec("to_msb",        32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        apply_vec("upper_carry",   32'hFFFF_0000, 32'h0001_0000, 1'b0, 33'h1_0000_0000);
        apply_vec("small_cin",     32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0003);
        apply_vec("mid_chain",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
        apply_vec("sum_in_rst",    32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 33'h0_1010_1011);

        // Register path: release reset away from an edge, then load on the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        a   = 32'hDEAD_BEEF;
        b   = 32'h2152_4111;
        cin = 1'b1;
        #1;
        check_val("sum_r_before_edge", sum_r, 33'h0_0000_0000);
        @(posedge clk);
        #1;
        check_val("sum_r_loaded", sum_r, 33'h1_0000_0001);
        check_val("sum_matches", sum, 33'h1_0000_0001);

        a   = 32'h0000_0010;
        b   = 32'h0000_0020;
        cin = 1'b0;
        @(posedge clk);
        #1;
        check_val("sum_r_next", sum_r, 33'h0_0000_0030);

        // Asynchronous clear mid-cycle with no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        check_val("sum_r_async_clr", sum_r, 33'h0_0000_0000);
        check_val("sum_during_rst", sum, 33'h0_0000_0030);
        @(negedge clk);
        rst = 1'b0;
        a   = 32'hFFFF_FFFF;
        b   = 32'h0000_0002;
        cin = 1'b0;
        @(posedge clk);
        #1;
        check_val("sum_r_after_rel", sum_r, 33'h1_0000_0001);

        // Random sweep against a bench-side 33-bit reference.
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            a   = ra;
            b   = rb;
            cin = rc;
            #10;
            check_val("random", sum, rexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
